// File: rtl/fifo_write_arbiter.sv
// Purpose: round-robin, burst-locked arbiter sharing one FIFO write port among N_REQ producers.
// Latency: 1 cycle from req_valid to grant; the data path is combinational while granted.
// Backpressure: fifo_input_ready goes only to the owner's req_ready; the grant and beat count hold while the FIFO is full.
//
// Ports:
//   clk, arst_n_in              clock and asynchronous active-low reset
//   req_data/req_valid          N_REQ producer streams (requester i at [i*WIDTH +: WIDTH])
//   req_ready                   per-producer ready; only the current owner can see 1
//   fifo_din/fifo_input_valid   to the FIFO write side
//   fifo_input_ready            from the FIFO (not full)
//   grant_id/grant_active       current owner index, high while a grant is held
//   req_last                    end-of-packet flags, present only when FIFO_ARB_LAST_EN is defined
//
// Build option: FIFO_ARB_LAST_EN enables release on a beat carrying req_last.

module register #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         arst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) q <= '0;
    else         q <= d;
  end
endmodule

module fifo_write_arbiter #(
  parameter  int WIDTH     = 8,
  parameter  int N_REQ     = 4,
  parameter  int BURST_LEN = 16,
  localparam int IDW       = $clog2(N_REQ),
  localparam int CNTW      = $clog2(BURST_LEN)
) (
  input  logic                   clk,
  input  logic                   arst_n_in,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  input  logic [N_REQ-1:0]       req_valid,
`ifdef FIFO_ARB_LAST_EN
  input  logic [N_REQ-1:0]       req_last,
`endif
  output logic [N_REQ-1:0]       req_ready,
  output logic [WIDTH-1:0]       fifo_din,
  output logic                   fifo_input_valid,
  input  logic                   fifo_input_ready,
  output logic [IDW-1:0]         grant_id,
  output logic                   grant_active
);

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_GRANTED = 1'b1;

  logic [0:0]      state, state_d;
  logic [IDW-1:0]  rr_ptr, rr_ptr_d;
  logic [IDW-1:0]  grant_d;
  logic [CNTW-1:0] beat_cnt, beat_cnt_d;

  register #(.W(1))    u_state (.clk(clk), .arst_n(arst_n_in), .d(state_d),    .q(state));
  register #(.W(IDW))  u_rr    (.clk(clk), .arst_n(arst_n_in), .d(rr_ptr_d),   .q(rr_ptr));
  register #(.W(IDW))  u_grant (.clk(clk), .arst_n(arst_n_in), .d(grant_d),    .q(grant_id));
  register #(.W(CNTW)) u_beat  (.clk(clk), .arst_n(arst_n_in), .d(beat_cnt_d), .q(beat_cnt));

  logic             granted;
  logic             found;
  logic [IDW-1:0]   winner;
  logic             owner_valid;
  logic [WIDTH-1:0] owner_data;
  logic             beat;
  logic             last_end;
  logic             release_now;

  assign granted = (state == ST_GRANTED);

  // Rotating priority in two passes: indices rr_ptr..N_REQ-1 first, then 0..rr_ptr-1.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (!found && (j >= int'(rr_ptr)) && req_valid[j]) begin
        found  = 1'b1;
        winner = IDW'(j);
      end
    end
    for (int j = 0; j < N_REQ; j++) begin
      if (!found && (j < int'(rr_ptr)) && req_valid[j]) begin
        found  = 1'b1;
        winner = IDW'(j);
      end
    end
  end

  // Owner select; also drives per-requester ready so only the owner can handshake.
  always_comb begin
    owner_valid = 1'b0;
    owner_data  = '0;
    req_ready   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_id == IDW'(i)) begin
        owner_valid  = req_valid[i];
        owner_data   = req_data[i*WIDTH +: WIDTH];
        req_ready[i] = granted && fifo_input_ready;
      end
    end
  end

  assign beat = granted && owner_valid && fifo_input_ready;

`ifdef FIFO_ARB_LAST_EN
  logic owner_last;
  always_comb begin
    owner_last = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_id == IDW'(i)) owner_last = req_last[i];
    end
  end
  assign last_end = beat && owner_last;
`else
  assign last_end = 1'b0;
`endif

  // Losing valid releases immediately; a stalled FIFO alone never does.
  assign release_now = granted &&
                       (!owner_valid ||
                        (beat && (beat_cnt == CNTW'(BURST_LEN - 1))) ||
                        last_end);

  always_comb begin
    state_d    = state;
    rr_ptr_d   = rr_ptr;
    grant_d    = grant_id;
    beat_cnt_d = beat_cnt;
    if (!granted) begin
      if (found) begin
        grant_d    = winner;
        beat_cnt_d = '0;
        state_d    = ST_GRANTED;
      end
    end else if (release_now) begin
      // Always return to IDLE so every release costs one idle cycle, even on regrant.
      state_d    = ST_IDLE;
      beat_cnt_d = '0;
      rr_ptr_d   = (grant_id == IDW'(N_REQ - 1)) ? '0 : grant_id + IDW'(1);
    end else if (beat) begin
      beat_cnt_d = beat_cnt + CNTW'(1);
    end
  end

  assign fifo_din         = granted ? owner_data : '0;
  assign fifo_input_valid = granted && owner_valid;
  assign grant_active     = granted;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
module tb_fifo_write_arbiter;
  localparam int W  = 8;
  localparam int N  = 4;
  localparam int BL = 16;

  logic           clk = 1'b0;
  logic           arst_n_in;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [W-1:0]   fifo_din;
  logic           fifo_input_valid;
  logic           fifo_input_ready;
  logic [1:0]     grant_id;
  logic           grant_active;
`ifdef FIFO_ARB_LAST_EN
  logic [N-1:0]   req_last;
`endif

  fifo_write_arbiter #(.WIDTH(W), .N_REQ(N), .BURST_LEN(BL)) dut (
    .clk              (clk),
    .arst_n_in        (arst_n_in),
    .req_data         (req_data),
    .req_valid        (req_valid),
`ifdef FIFO_ARB_LAST_EN
    .req_last         (req_last),
`endif
    .req_ready        (req_ready),
    .fifo_din         (fifo_din),
    .fifo_input_valid (fifo_input_valid),
    .fifo_input_ready (fifo_input_ready),
    .grant_id         (grant_id),
    .grant_active     (grant_active)
  );

  always #5 clk = ~clk;

  // Producer word queues: requester r, word k carries r*64+k.
  logic [W-1:0] wq [N][$];
  logic         lq [N][$];
  bit           en [N];
  int           total = 0;
  int           bad   = 0;
  int           cnt [N];

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      req_valid[i]       = en[i] && (wq[i].size() > 0);
      req_data[i*W +: W] = (wq[i].size() > 0) ? wq[i][0] : 8'h00;
`ifdef FIFO_ARB_LAST_EN
      req_last[i]        = (lq[i].size() > 0) ? lq[i][0] : 1'b0;
`endif
    end
  endtask

  task automatic settle();
    drive_inputs();
    #1;
  endtask

  task automatic advance();
    for (int i = 0; i < N; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        void'(wq[i].pop_front());
        void'(lq[i].pop_front());
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int r, input int first, input int n, input bit mark_last);
    for (int k = first; k < first + n; k++) begin
      wq[r].push_back(8'(r*64 + k));
      lq[r].push_back(mark_last && (k == first + n - 1));
    end
  endtask

  task automatic clear_all();
    for (int i = 0; i < N; i++) begin
      wq[i].delete();
      lq[i].delete();
      en[i]  = 1'b0;
      cnt[i] = 0;
    end
    drive_inputs();
  endtask

  task automatic apply_reset();
    arst_n_in        = 1'b0;
    fifo_input_ready = 1'b1;
    clear_all();
    repeat (2) @(posedge clk);
    #3 arst_n_in = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    arst_n_in        = 1'b0;
    fifo_input_ready = 1'b1;
    clear_all();
    #2;
    total++;
    if (req_ready !== 4'b0 || fifo_input_valid !== 1'b0 || fifo_din !== 8'h00 ||
        grant_active !== 1'b0 || grant_id !== 2'd0) begin
      bad++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b din=%h act=%b id=%0d want all zero",
               req_ready, fifo_input_valid, fifo_din, grant_active, grant_id);
    end
    total++;
    if (dut.rr_ptr !== 2'd0 || dut.beat_cnt !== 4'd0) begin
      bad++;
      $display("FAIL reset_state: got rr=%0d cnt=%0d want 0 0", dut.rr_ptr, dut.beat_cnt);
    end
    apply_reset();
    for (int c = 0; c < 3; c++) begin
      settle();
      total++;
      if (grant_active !== 1'b0 || fifo_input_valid !== 1'b0) begin
        bad++;
        $display("FAIL reset_idle c=%0d: got act=%b vld=%b want 0 0", c, grant_active, fifo_input_valid);
      end
      advance();
    end
  endtask

  // Single requester, 20 words: 16-beat burst, idle cycle, 4 beats, valid drop.
  task automatic test_single_burst();
    logic exp_act, exp_beat;
    apply_reset();
    load(0, 0, 20, 1'b0);
    en[0] = 1'b1;
    for (int c = 0; c < 24; c++) begin
      settle();
      exp_act  = (c >= 1 && c <= 16) || (c >= 18 && c <= 22);
      exp_beat = (c >= 1 && c <= 16) || (c >= 18 && c <= 21);
      total++;
      if (grant_active !== exp_act || (exp_act && grant_id !== 2'd0) ||
          (fifo_input_valid && fifo_input_ready) !== exp_beat) begin
        bad++;
        $display("FAIL single_sched c=%0d: got act=%b id=%0d beat=%b want act=%b id=0 beat=%b",
                 c, grant_active, grant_id, fifo_input_valid && fifo_input_ready, exp_act, exp_beat);
      end
      if (exp_beat) begin
        total++;
        if (fifo_din !== 8'(cnt[0])) begin
          bad++;
          $display("FAIL single_data c=%0d: got %h want %h", c, fifo_din, 8'(cnt[0]));
        end
        cnt[0]++;
      end
      advance();
    end
  endtask

  // All four always valid: 0,1,2,3,0 with one idle cycle between grants.
  task automatic test_round_robin();
    logic       exp_act;
    logic [1:0] exp_g;
    logic [3:0] exp_rdy;
    apply_reset();
    for (int r = 0; r < N; r++) begin
      load(r, 0, 40, 1'b0);
      en[r] = 1'b1;
    end
    for (int c = 0; c < 85; c++) begin
      settle();
      exp_act = (c % 17) != 0;
      exp_g   = 2'((c / 17) % 4);
      exp_rdy = exp_act ? (4'b0001 << exp_g) : 4'b0000;
      total++;
      if (grant_active !== exp_act || (exp_act && grant_id !== exp_g) || req_ready !== exp_rdy) begin
        bad++;
        $display("FAIL rr_sched c=%0d: got act=%b id=%0d rdy=%b want act=%b id=%0d rdy=%b",
                 c, grant_active, grant_id, req_ready, exp_act, exp_g, exp_rdy);
      end
      if (exp_act) begin
        total++;
        if (fifo_din !== 8'(exp_g*64 + cnt[exp_g])) begin
          bad++;
          $display("FAIL rr_data c=%0d: got %h want %h", c, fifo_din, 8'(exp_g*64 + cnt[exp_g]));
        end
        cnt[exp_g]++;
      end
      if (c == 68) begin
        total++;
        if (dut.rr_ptr !== 2'd0) begin
          bad++;
          $display("FAIL rr_wrap: got rr=%0d want 0", dut.rr_ptr);
        end
      end
      advance();
    end
  endtask

  // FIFO full for 5 cycles after beat 6 of a grant to requester 1.
  task automatic test_fifo_stall();
    logic exp_act, exp_beat;
    apply_reset();
    load(1, 0, 20, 1'b0);
    en[1] = 1'b1;
    for (int c = 0; c < 24; c++) begin
      fifo_input_ready = !(c >= 7 && c <= 11);
      settle();
      exp_act  = (c >= 1 && c <= 21) || (c == 23);
      exp_beat = exp_act && !(c >= 7 && c <= 11);
      total++;
      if (grant_active !== exp_act || (exp_act && grant_id !== 2'd1) ||
          (fifo_input_valid && fifo_input_ready) !== exp_beat) begin
        bad++;
        $display("FAIL stall_sched c=%0d: got act=%b id=%0d beat=%b want act=%b id=1 beat=%b",
                 c, grant_active, grant_id, fifo_input_valid && fifo_input_ready, exp_act, exp_beat);
      end
      if (c >= 7 && c <= 11) begin
        total++;
        if (fifo_input_valid !== 1'b1 || fifo_din !== 8'd70 || req_ready !== 4'b0) begin
          bad++;
          $display("FAIL stall_hold c=%0d: got vld=%b din=%h rdy=%b want 1 46 0000",
                   c, fifo_input_valid, fifo_din, req_ready);
        end
      end
      if (c == 9) begin
        total++;
        if (dut.beat_cnt !== 4'd6) begin
          bad++;
          $display("FAIL stall_cnt: got %0d want 6", dut.beat_cnt);
        end
      end
      if (exp_beat) begin
        total++;
        if (fifo_din !== 8'(64 + cnt[1])) begin
          bad++;
          $display("FAIL stall_data c=%0d: got %h want %h", c, fifo_din, 8'(64 + cnt[1]));
        end
        cnt[1]++;
      end
      advance();
    end
    fifo_input_ready = 1'b1;
  endtask

  // Requester 2 drops valid after 3 beats while 0 and 3 wait: next 3, then 0.
  task automatic test_valid_drop();
    logic       exp_act, exp_beat;
    logic [1:0] exp_g;
    apply_reset();
    load(2, 0, 3, 1'b0);
    load(0, 0, 20, 1'b0);
    load(3, 0, 20, 1'b0);
    en[2] = 1'b1;
    for (int c = 0; c < 24; c++) begin
      if (c == 1) begin
        en[0] = 1'b1;
        en[3] = 1'b1;
      end
      settle();
      exp_act  = (c >= 1 && c <= 4) || (c >= 6 && c <= 21) || (c == 23);
      exp_beat = exp_act && (c != 4);
      exp_g    = (c <= 4) ? 2'd2 : (c <= 21) ? 2'd3 : 2'd0;
      total++;
      if (grant_active !== exp_act || (exp_act && grant_id !== exp_g) ||
          (fifo_input_valid && fifo_input_ready) !== exp_beat) begin
        bad++;
        $display("FAIL drop_sched c=%0d: got act=%b id=%0d beat=%b want act=%b id=%0d beat=%b",
                 c, grant_active, grant_id, fifo_input_valid && fifo_input_ready, exp_act, exp_g, exp_beat);
      end
      if (exp_beat) begin
        total++;
        if (fifo_din !== 8'(exp_g*64 + cnt[exp_g])) begin
          bad++;
          $display("FAIL drop_data c=%0d: got %h want %h", c, fifo_din, 8'(exp_g*64 + cnt[exp_g]));
        end
        cnt[exp_g]++;
      end
      advance();
    end
  endtask

  // Asynchronous reset in the middle of a burst, then a fresh grant from pointer 0.
  task automatic test_reset_mid_burst();
    apply_reset();
    load(0, 0, 20, 1'b0);
    en[0] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      settle();
      advance();
    end
    settle();
    total++;
    if (grant_active !== 1'b1 || fifo_input_valid !== 1'b1) begin
      bad++;
      $display("FAIL midrst_pre: got act=%b vld=%b want 1 1", grant_active, fifo_input_valid);
    end
    arst_n_in = 1'b0;
    #1;
    total++;
    if (req_ready !== 4'b0 || fifo_input_valid !== 1'b0 || fifo_din !== 8'h00 ||
        grant_active !== 1'b0 || grant_id !== 2'd0) begin
      bad++;
      $display("FAIL midrst_outputs: got rdy=%b vld=%b din=%h act=%b id=%0d want all zero",
               req_ready, fifo_input_valid, fifo_din, grant_active, grant_id);
    end
    clear_all();
    load(1, 0, 4, 1'b0);
    load(2, 0, 4, 1'b0);
    en[1] = 1'b1;
    en[2] = 1'b1;
    drive_inputs();
    @(posedge clk);
    #3 arst_n_in = 1'b1;
    @(posedge clk);
    #1;
    settle();
    total++;
    if (grant_active !== 1'b1 || grant_id !== 2'd1 || fifo_din !== 8'd64) begin
      bad++;
      $display("FAIL midrst_regrant: got act=%b id=%0d din=%h want 1 1 40", grant_active, grant_id, fifo_din);
    end
  endtask

`ifdef FIFO_ARB_LAST_EN
  // Packet of 5 ends early on last; packet of 20 is split 16 + 4.
  task automatic test_last();
    logic exp_act;
    apply_reset();
    load(1, 0, 5, 1'b1);
    load(1, 5, 20, 1'b1);
    en[1] = 1'b1;
    for (int c = 0; c < 29; c++) begin
      settle();
      exp_act = (c >= 1 && c <= 5) || (c >= 7 && c <= 22) || (c >= 24 && c <= 27);
      total++;
      if (grant_active !== exp_act || (fifo_input_valid && fifo_input_ready) !== exp_act) begin
        bad++;
        $display("FAIL last_sched c=%0d: got act=%b beat=%b want %b", c, grant_active,
                 fifo_input_valid && fifo_input_ready, exp_act);
      end
      if (exp_act) begin
        total++;
        if (fifo_din !== 8'(64 + cnt[1])) begin
          bad++;
          $display("FAIL last_data c=%0d: got %h want %h", c, fifo_din, 8'(64 + cnt[1]));
        end
        cnt[1]++;
      end
      advance();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_burst();
    test_round_robin();
    test_fifo_stall();
    test_valid_drop();
    test_reset_mid_burst();
`ifdef FIFO_ARB_LAST_EN
    test_last();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
